// File: rtl/pipe_pkg.sv
// Shared types and default widths for the handshaked pipeline-stage registers.
// Default widths describe the MEM/WB bundle of the CPU datapath.
package pipe_pkg;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  localparam int MEMWB_DATA_W   = 101;
  localparam int MEMWB_CTRL_W   = 4;
  localparam int STALL_CNT_W_DF = 16;

  function automatic occ_t occ_count(input logic main_valid, input logic skid_valid);
    return (main_valid && skid_valid) ? OCC_FULL :
           (main_valid || skid_valid) ? OCC_ONE  : OCC_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stage bus: upstream and downstream handshakes, flush and status.
// The master drives the stimulus side, the slave is the stage register.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W      = MEMWB_DATA_W,
  parameter int CTRL_W      = MEMWB_CTRL_W,
  parameter int STALL_CNT_W = STALL_CNT_W_DF
);
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data;
  logic [CTRL_W-1:0]      in_ctrl;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [CTRL_W-1:0]      out_ctrl;
  occ_t                   occupancy;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output flush, in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one pipeline entry, a valid flag plus a payload register.
// Clear only drops the valid flag; the payload is kept until the next load.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = d_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the payload is reset too, so out_data reads 0 after reset rather than X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register with flush, bubble-safe control and stall counter.
// Define PIPE_SKID_EN for the 2-entry skid build with a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W      = MEMWB_DATA_W,
  parameter int CTRL_W      = MEMWB_CTRL_W,
  parameter int STALL_CNT_W = STALL_CNT_W_DF
) (
  input logic             clk,
  input logic             rst_n,
  pipe_stage_reg_if.slave bus
);

  localparam int W = DATA_W + CTRL_W;

  logic         main_valid, main_load, main_clr;
  logic [W-1:0] main_q, main_din;
  logic         xfer_in, xfer_out;

  assign xfer_in  = bus.in_valid && bus.in_ready;
  assign xfer_out = main_valid && bus.out_ready;

`ifdef PIPE_SKID_EN
  logic         skid_valid, skid_load, skid_clr;
  logic [W-1:0] skid_q;

  // in_ready comes straight from the skid flop: no path from out_ready.
  assign bus.in_ready = !skid_valid;

  // Main refills from skid first so order stays FIFO; skid only catches a
  // beat arriving while main is full and not draining.
  assign main_load = (skid_valid && xfer_out) || (xfer_in && (!main_valid || xfer_out));
  assign main_din  = skid_valid ? skid_q : {bus.in_data, bus.in_ctrl};
  assign main_clr  = bus.flush || (xfer_out && !main_load);
  assign skid_load = xfer_in && main_valid && !xfer_out;
  assign skid_clr  = bus.flush || (skid_valid && xfer_out);

  pipe_slot #(.W(W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clr_i   (skid_clr),
    .d_i     ({bus.in_data, bus.in_ctrl}),
    .valid_o (skid_valid),
    .q_o     (skid_q)
  );

  assign bus.occupancy = occ_count(main_valid, skid_valid);
`else
  assign bus.in_ready  = !main_valid || bus.out_ready;
  assign main_load     = xfer_in;
  assign main_din      = {bus.in_data, bus.in_ctrl};
  assign main_clr      = bus.flush || (xfer_out && !xfer_in);
  assign bus.occupancy = occ_count(main_valid, 1'b0);
`endif

  // Flush reaches the slot as clear, which outranks load and drops the input.
  pipe_slot #(.W(W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (main_load),
    .clr_i   (main_clr),
    .d_i     (main_din),
    .valid_o (main_valid),
    .q_o     (main_q)
  );

  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_q[W-1:CTRL_W];
  assign bus.out_ctrl  = main_valid ? main_q[CTRL_W-1:0] : '0;

  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (main_valid && !bus.out_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: table-driven vectors with a scoreboard,
// plus hand-written mid-stream reset and stall-counter saturation sequences.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = MEMWB_DATA_W;
  localparam int CW = MEMWB_CTRL_W;

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic [3:0] ctrl;
    logic       ordy;
    logic       flush;
    logic       exp_ir;
    logic       exp_ov;
    logic [1:0] exp_occ;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } sb_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   stall_model;
  vec_t tbl[$];
  sb_t  sb[$];

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .STALL_CNT_W(16)) bus ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .STALL_CNT_W(4))  sat_bus ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .STALL_CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .STALL_CNT_W(4)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sat_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [7:0] data, input logic [3:0] ctrl,
                              input logic ordy, input logic flush, input logic exp_ir,
                              input logic exp_ov, input logic [1:0] exp_occ);
    vec_t v;
    v.vld = vld; v.data = data; v.ctrl = ctrl; v.ordy = ordy; v.flush = flush;
    v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.exp_occ = exp_occ;
    return v;
  endfunction

  // Called at a negedge: drive, compare, update scoreboard, advance one cycle.
  task automatic apply(input int idx, input vec_t v);
    sb_t item;
    bus.in_valid  = v.vld;
    bus.in_data   = DW'(v.data);
    bus.in_ctrl   = v.ctrl;
    bus.out_ready = v.ordy;
    bus.flush     = v.flush;
    #1;
    check($sformatf("v%0d_in_ready", idx), bus.in_ready, v.exp_ir);
    check($sformatf("v%0d_out_valid", idx), bus.out_valid, v.exp_ov);
    check($sformatf("v%0d_occupancy", idx), bus.occupancy, v.exp_occ);
    check($sformatf("v%0d_stall_cnt", idx), bus.stall_cnt, stall_model);
    if (!v.exp_ov) check($sformatf("v%0d_bubble_ctrl", idx), bus.out_ctrl, 0);
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL v%0d_unexpected_out: got data %0h expected no output", idx, bus.out_data);
      end else begin
        item = sb.pop_front();
        check($sformatf("v%0d_out_data", idx), bus.out_data, item.data);
        check($sformatf("v%0d_out_ctrl", idx), bus.out_ctrl, item.ctrl);
      end
    end
    if (v.flush) sb.delete();
    else if (bus.in_valid && bus.in_ready) begin
      item.data = bus.in_data;
      item.ctrl = bus.in_ctrl;
      sb.push_back(item);
    end
    if (v.exp_ov && !v.ordy) stall_model++;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0; stall_model = 0;
    rst_n = 1'b0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ctrl = '0; bus.out_ready = 1'b0;
    sat_bus.flush = 1'b0; sat_bus.in_valid = 1'b0; sat_bus.in_data = '0;
    sat_bus.in_ctrl = '0; sat_bus.out_ready = 1'b0;

    // Streaming: 1..8 back-to-back, then drain.
    tbl.push_back(mk(1, 8'h1, 4'b1010, 1, 0, 1, 0, 0));
    for (int i = 2; i <= 8; i++) tbl.push_back(mk(1, 8'(i), 4'b1010, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 8'h0, 4'b0000, 1, 0, 1, 1, 1));
    // Backpressure: A taken, then 5 stalled cycles with B offered, then release.
    tbl.push_back(mk(1, 8'hA, 4'b0011, 1, 0, 1, 0, 0));
`ifdef PIPE_SKID_EN
    tbl.push_back(mk(1, 8'hB, 4'b0101, 0, 0, 1, 1, 1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 8'h0, 4'b0000, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 8'h0, 4'b0000, 1, 0, 0, 1, 2));
    tbl.push_back(mk(0, 8'h0, 4'b0000, 1, 0, 1, 1, 1));
`else
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 8'hB, 4'b0101, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 8'hB, 4'b0101, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 8'h0, 4'b0000, 1, 0, 1, 1, 1));
`endif
    tbl.push_back(mk(0, 8'h0, 4'b0000, 1, 0, 1, 0, 0));
    // Flush priority: 0xC offered alongside flush must never appear.
    tbl.push_back(mk(1, 8'hD, 4'b0110, 0, 0, 1, 0, 0));
`ifdef PIPE_SKID_EN
    tbl.push_back(mk(1, 8'hE, 4'b0111, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 8'hC, 4'b1100, 0, 1, 0, 1, 2));
`else
    tbl.push_back(mk(1, 8'hC, 4'b1100, 1, 1, 1, 1, 1));
`endif
    tbl.push_back(mk(0, 8'h0, 4'b0000, 1, 0, 1, 0, 0));
    // Bubble control: control bits offered without valid never reach out_ctrl.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'hFF, 4'b1111, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'hFF, 4'b1111, 1, 0, 1, 0, 0));

    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_ctrl", bus.out_ctrl, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_occupancy", bus.occupancy, 0);
    check("rst_stall_cnt", bus.stall_cnt, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(i, tbl[i]);
    check("sb_drained", sb.size(), 0);

    // Mid-stream reset with one entry held under backpressure.
    bus.in_valid = 1'b1; bus.in_data = DW'(8'h5A); bus.in_ctrl = 4'b1010; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("mid_pre_occupancy", bus.occupancy, 1);
    check("mid_pre_stall_cnt", bus.stall_cnt, stall_model + 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_out_valid", bus.out_valid, 0);
    check("mid_out_ctrl", bus.out_ctrl, 0);
    check("mid_out_data", bus.out_data, 0);
    check("mid_occupancy", bus.occupancy, 0);
    check("mid_stall_cnt", bus.stall_cnt, 0);
    sb.delete();
    stall_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_data = DW'(8'h77); bus.in_ctrl = 4'b0001; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("post_rst_out_valid", bus.out_valid, 1);
    check("post_rst_out_data", bus.out_data, 8'h77);
    check("post_rst_out_ctrl", bus.out_ctrl, 4'b0001);
    @(negedge clk);

    // Saturation on the 4-bit counter instance.
    sat_bus.in_valid = 1'b1; sat_bus.in_data = DW'(8'h3); sat_bus.in_ctrl = 4'b0001;
    @(negedge clk);
    sat_bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("sat_mid_count", sat_bus.stall_cnt, 10);
    repeat (10) @(negedge clk);
    check("sat_at_20", sat_bus.stall_cnt, 15);
    repeat (3) @(negedge clk);
    check("sat_held", sat_bus.stall_cnt, 15);
    check("sat_out_valid", sat_bus.out_valid, 1);
    check("sat_out_ctrl", sat_bus.out_ctrl, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
